// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution MAC engine.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } conv_state_e;

    // Default geometry, used to publish the nominal product/sum widths.
    localparam int CONV_K_H  = 3;
    localparam int CONV_K_W  = 3;
    localparam int CONV_IN_W = 8;
    localparam int CONV_W_W  = 8;

    // Unsigned pixel gets a zero sign bit, so each product needs IN_W+W_W+1 bits.
    function automatic int prod_width(input int in_w, input int w_w);
        return in_w + w_w + 1;
    endfunction

    // Summing `taps` products grows the word by clog2(taps) bits.
    function automatic int sum_width(input int in_w, input int w_w, input int taps);
        return prod_width(in_w, w_w) + $clog2(taps);
    endfunction

    localparam int PROD_W = prod_width(CONV_IN_W, CONV_W_W);
    localparam int SUM_W  = sum_width(CONV_IN_W, CONV_W_W, CONV_K_H * CONV_K_W);

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } sat_res_t;

    // Adds sum to acc and clamps to the signed range of an acc_w-bit word.
    // Operands are carried in 64 bits, so acc_w must stay well below 64.
    function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                         input logic signed [63:0] sum,
                                         input int                 acc_w);
        logic signed [63:0] total;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_res_t           res;
        total   = acc + sum;
        max_v   = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        res.ovf = 1'b0;
        res.val = total;
        if (total > max_v) begin
            res.val = max_v;
            res.ovf = 1'b1;
        end else if (total < min_v) begin
            res.val = min_v;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_dot_stage.sv
// Registered K_H x K_W product array followed by a combinational adder tree.
module conv_dot_stage
    import conv_pkg::*;
#(
    parameter  int K_H  = 3,
    parameter  int K_W  = 3,
    parameter  int IN_W = 8,
    parameter  int W_W  = 8,
    localparam int P_W  = prod_width(IN_W, W_W),
    localparam int S_W  = sum_width(IN_W, W_W, K_H * K_W)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_vld,
    input  logic [K_H-1:0][K_W-1:0][IN_W-1:0]    i_img,
    input  logic [K_H-1:0][K_W-1:0][W_W-1:0]     i_w,
    output logic                                 o_vld_p1,
    output logic signed [S_W-1:0]                o_sum_p1
);

    logic signed [P_W-1:0] r_prod_p1 [K_H][K_W];
    logic                  r_vld_p1;
    logic signed [S_W-1:0] w_sum_p1;

    // Stage 1 valid: tracks whether the product array holds a live beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
        end
    end

    // Stage 1 data: pixel zero-extended to signed, times signed weight.
    always_ff @(posedge clk) begin
        if (i_vld) begin
            for (int r = 0; r < K_H; r++) begin
                for (int c = 0; c < K_W; c++) begin
                    r_prod_p1[r][c] <= P_W'($signed({1'b0, i_img[r][c]}))
                                     * P_W'($signed(i_w[r][c]));
                end
            end
        end
    end

    // Stage 2 adder tree: sign-extend every product and sum them.
    always_comb begin
        w_sum_p1 = '0;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
                w_sum_p1 = w_sum_p1 + S_W'(r_prod_p1[r][c]);
            end
        end
    end

    assign o_vld_p1 = r_vld_p1;
    assign o_sum_p1 = w_sum_p1;

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-channel convolution MAC: bias seed, saturating accumulate, optional ReLU.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 32,
    parameter int CH_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [CH_W-1:0]                   num_ch,
    input  logic signed [ACC_W-1:0]           bias,
    input  logic                              relu_en,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [K_H-1:0][K_W-1:0][IN_W-1:0] img,
    input  logic [K_H-1:0][K_W-1:0][W_W-1:0]  w,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [ACC_W-1:0]           result,
    output logic                              ovf,
    output logic                              busy
);

    localparam int S_W = sum_width(IN_W, W_W, K_H * K_W);

    conv_state_e             r_state;
    conv_state_e             w_next;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_busy;
    logic                    w_accept;
    logic                    w_last_beat;

    logic [CH_W-1:0]         r_num_ch;
    logic [CH_W-1:0]         r_beat;
    logic                    r_relu;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_result;
    logic                    r_ovf;

    logic                    w_vld_p1;
    logic signed [S_W-1:0]   w_sum_p1;
    sat_res_t                w_sat;

    assign w_accept    = (r_state == ST_ACCUM) && in_valid;
    assign w_last_beat = (r_beat == r_num_ch - CH_W'(1));

    conv_dot_stage #(
        .K_H  (K_H),
        .K_W  (K_W),
        .IN_W (IN_W),
        .W_W  (W_W)
    ) u_dot (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vld    (w_accept),
        .i_img    (img),
        .i_w      (w),
        .o_vld_p1 (w_vld_p1),
        .o_sum_p1 (w_sum_p1)
    );

    assign w_sat = sat_add(64'(r_acc), 64'(w_sum_p1), ACC_W);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last_beat) w_next = ST_DRAIN;
            end
            // The last beat's product is in stage 1 on entry; leave once it has been added.
            ST_DRAIN: begin
                if (!w_vld_p1) w_next = ST_OUT;
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Per-pixel context, beat counter, accumulator, sticky overflow and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_ch <= '0;
            r_beat   <= '0;
            r_relu   <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_num_ch <= (num_ch == '0) ? CH_W'(1) : num_ch;
                r_beat   <= '0;
                r_relu   <= relu_en;
                r_acc    <= bias;
                r_ovf    <= 1'b0;
            end
            if (w_accept) begin
                r_beat <= r_beat + CH_W'(1);
            end
            if (w_vld_p1) begin
                r_acc <= ACC_W'(w_sat.val);
                if (w_sat.ovf) r_ovf <= 1'b1;
            end
            if (r_state == ST_DRAIN && !w_vld_p1) begin
                r_result <= (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign result    = r_result;
    assign ovf       = r_ovf;

endmodule
